// File: rtl/regsel_sequencer.sv
// Register-select sequencer: maps a logical register code onto a one-hot physical
// select and runs a fixed four-state access cycle, tracking AF/main/DE-HL bank state.
module regsel_sequencer (
    input  logic        eclk,
    input  logic        erst,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  code,
    input  logic        join_i,
    input  logic        ex_af,
    input  logic        exx,
    input  logic        ex_dehl,
    output logic [13:0] regsel,
    output logic        pc_wr,
    output logic        reg_wr,
    output logic        r_p,
    output logic        ack,
    output logic        err,
    output logic        bank_af,
    output logic        bank_main,
    output logic [1:0]  swap
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [13:0] SEL_HL1 = 14'h0040;
    localparam logic [13:0] SEL_HL0 = 14'h0080;
    localparam logic [13:0] SEL_DE1 = 14'h0100;
    localparam logic [13:0] SEL_DE0 = 14'h0200;
    localparam logic [13:0] SEL_BC1 = 14'h0400;
    localparam logic [13:0] SEL_BC0 = 14'h0800;
    localparam logic [13:0] SEL_AF1 = 14'h1000;
    localparam logic [13:0] SEL_AF0 = 14'h2000;

    logic [1:0]  state_q, state_d;
    logic [13:0] sel_q, sel_d;
    logic        join_q, join_d;
    logic        wr_q, wr_d;
    logic        left_q, left_d;
    logic        inv_q, inv_d;
    logic        bank_af_q, bank_af_d;
    logic        bank_main_q, bank_main_d;
    logic [1:0]  swap_q, swap_d;

    logic [13:0] sel_map;
    logic        left_map;
    logic        inv_map;
    logic        cur_swap;
    logic        active;

    assign cur_swap = swap_q[bank_main_q];

    // Mapping uses the bank state as it stands before any exchange pulse of this cycle.
    always_comb begin
        sel_map  = '0;
        left_map = 1'b0;
        inv_map  = 1'b0;
        case (code)
            4'd0, 4'd1:                   begin sel_map = 14'd1 << code; left_map = 1'b1; end
            4'd2, 4'd3, 4'd4, 4'd5:       sel_map = 14'd1 << code;
            4'd6: sel_map = cur_swap ? (bank_main_q ? SEL_DE1 : SEL_DE0)
                                     : (bank_main_q ? SEL_HL1 : SEL_HL0);
            4'd7: sel_map = cur_swap ? (bank_main_q ? SEL_HL1 : SEL_HL0)
                                     : (bank_main_q ? SEL_DE1 : SEL_DE0);
            4'd8: sel_map = bank_main_q ? SEL_BC1 : SEL_BC0;
            4'd9: sel_map = bank_af_q ? SEL_AF1 : SEL_AF0;
            default: inv_map = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        join_d  = join_q;
        wr_d    = wr_q;
        left_d  = left_q;
        inv_d   = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_SELECT;
                    sel_d   = sel_map;
                    join_d  = join_i;
                    wr_d    = we;
                    left_d  = left_map;
                    inv_d   = inv_map;
                end
            end
            ST_SELECT: state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign bank_af_d   = bank_af_q ^ ex_af;
    assign bank_main_d = bank_main_q ^ exx;

    // ex_dehl targets the bank selected before a simultaneous exx takes effect.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_swap
            assign swap_d[gi] = swap_q[gi] ^ (ex_dehl & (bank_main_q == 1'(gi)));
        end
    endgenerate

    always_ff @(posedge eclk) begin
        if (erst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            join_q      <= 1'b0;
            wr_q        <= 1'b0;
            left_q      <= 1'b0;
            inv_q       <= 1'b0;
            bank_af_q   <= 1'b0;
            bank_main_q <= 1'b0;
            swap_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            join_q      <= join_d;
            wr_q        <= wr_d;
            left_q      <= left_d;
            inv_q       <= inv_d;
            bank_af_q   <= bank_af_d;
            bank_main_q <= bank_main_d;
            swap_q      <= swap_d;
        end
    end

    assign active    = (state_q == ST_SELECT) || (state_q == ST_ACCESS);
    assign regsel    = active ? sel_q : '0;
    assign r_p       = active & join_q;
    assign pc_wr     = (state_q == ST_ACCESS) & wr_q & left_q;
    assign reg_wr    = (state_q == ST_ACCESS) & wr_q & ~left_q & ~inv_q;
    assign ack       = (state_q == ST_DONE);
    assign err       = (state_q == ST_DONE) & inv_q;
    assign bank_af   = bank_af_q;
    assign bank_main = bank_main_q;
    assign swap      = swap_q;

endmodule
